// File: rtl/load_align_pkg.sv
// load_align_pkg: size codes, FSM states and byte-count helper shared by the load align unit.
package load_align_pkg;
   localparam logic [1:0] SZ_WORD  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_BYTE  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;
   typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;
   function automatic logic [3:0] size_bytes(input logic [1:0] size, input int data_w);
      return size == SZ_BYTE ? 4'd1 : size == SZ_HALF ? 4'd2 : size == SZ_DWORD ? 4'd8 : 4'(data_w / 8);
   endfunction
endpackage

// File: rtl/load_align_unit_lane_extract.sv
// lane_extract: picks the addressed bytes big-endian from a two-word window and extends them.
module lane_extract
   import load_align_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFS_W  = 2
) (
   input  logic [2*DATA_W-1:0] i_pair,
   input  logic [OFS_W-1:0]    i_ofs,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   output logic [DATA_W-1:0]   o_data
);
   logic [DATA_W-1:0] w_top;
   logic              w_sb;
   // Shift the addressed byte up to the MSB lane; the result then sits left-justified in w_top.
   always_comb begin
      w_top  = DATA_W'((i_pair << {i_ofs, 3'b000}) >> DATA_W);
      w_sb   = ~i_unsigned & w_top[DATA_W-1];
      o_data = i_size == SZ_BYTE ? {{(DATA_W-8){w_sb}}, w_top[DATA_W-1 -: 8]} :
               i_size == SZ_HALF ? {{(DATA_W-16){w_sb}}, w_top[DATA_W-1 -: 16]} : w_top;
   end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: single-outstanding load path issuing aligned reads and returning extended data.
// LOAD_ALIGN_MISALIGN_SPLIT_EN: word-crossing loads use two reads instead of returning an error.
module load_align_unit
   import load_align_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);
   localparam int OFS_W = $clog2(DATA_W / 8);
   localparam int BYTES = DATA_W / 8;
   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_addr, w_base;
   logic [1:0]          r_size;
   logic                r_uns, r_err, w_illegal, w_bad;
   logic [DATA_W-1:0]   r_data, w_ext;
   logic [2*DATA_W-1:0] w_pair;
   logic [3:0]          w_nb, w_ofs;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
   logic [DATA_W-1:0]   r_w0;
   logic                r_split;
   logic [4:0]          w_end;
`else
   logic                w_misal;
`endif
   always_comb begin
      w_nb      = size_bytes(req_size, DATA_W);
      w_ofs     = 4'(req_addr[OFS_W-1:0]);
      w_illegal = (req_size == SZ_DWORD) && (DATA_W == 32);
      w_base    = {r_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      w_end     = {1'b0, w_ofs} + {1'b0, w_nb};
      w_bad     = w_illegal;
      w_pair    = r_state == S_WAIT1 ? {r_w0, mem_rdata} : {mem_rdata, {DATA_W{1'b0}}};
`else
      w_misal   = (w_ofs & (w_nb - 4'd1)) != 4'd0;
      w_bad     = w_illegal | w_misal;
      w_pair    = {mem_rdata, {DATA_W{1'b0}}};
`endif
   end
   lane_extract #(.DATA_W(DATA_W), .OFS_W(OFS_W)) u_lane (
      .i_pair    (w_pair),
      .i_ofs     (r_addr[OFS_W-1:0]),
      .i_size    (r_size),
      .i_unsigned(r_uns),
      .o_data    (w_ext)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next        = r_state;
      req_ready     = r_state == S_IDLE;
      mem_req_valid = r_state == S_REQ0 || r_state == S_REQ1;
      mem_addr      = r_state == S_REQ0 ? w_base : r_state == S_REQ1 ? w_base + ADDR_W'(BYTES) : '0;
      rsp_valid     = r_state == S_RESP;
      rsp_data      = r_data;
      rsp_err       = r_err;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = w_bad ? S_RESP : S_REQ0;
         S_REQ0:  if (mem_req_ready) w_next = S_WAIT0;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
         S_WAIT0: if (mem_rsp_valid) w_next = r_split ? S_REQ1 : S_RESP;
         S_REQ1:  if (mem_req_ready) w_next = S_WAIT1;
         S_WAIT1: if (mem_rsp_valid) w_next = S_RESP;
`else
         S_WAIT0: if (mem_rsp_valid) w_next = S_RESP;
`endif
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_size <= SZ_WORD;
         r_uns  <= 1'b0;
         r_err  <= 1'b0;
         r_data <= '0;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
         r_w0    <= '0;
         r_split <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE && req_valid) begin
            r_addr <= req_addr;
            r_size <= req_size;
            r_uns  <= req_unsigned;
            r_err  <= w_bad;
            r_data <= '0;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
            r_split <= w_end > 5'(BYTES);
`endif
         end
         // The second read overwrites the partial result built from the first.
         if ((r_state == S_WAIT0 || r_state == S_WAIT1) && mem_rsp_valid) r_data <= w_ext;
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
         if (r_state == S_WAIT0 && mem_rsp_valid) r_w0 <= mem_rdata;
`endif
      end
   end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: vector table, corner sequences and random loads against a byte-level model.
module tb_load_align_unit;
   logic clk = 0, rst_n = 1;
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   logic        req_valid = 0, req_unsigned = 0, mem_req_ready = 1, rsp_ready = 1;
   logic [31:0] req_addr = 0;
   logic [1:0]  req_size = 0;
   logic        req_ready, mem_req_valid, mem_rsp_valid, rsp_valid, rsp_err;
   logic [31:0] mem_addr, mem_rdata, rsp_data;
   logic        mem_auto = 1, auto_v = 0, man_v = 0;
   logic [31:0] auto_d = 0, man_d = 0;
   int          reads = 0;
   logic [31:0] mem32 [logic [31:0]];
   assign mem_rsp_valid = mem_auto ? auto_v : man_v;
   assign mem_rdata     = mem_auto ? auto_d : man_d;
   load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err));
   logic        b_req_valid = 0, b_req_unsigned = 0;
   logic [31:0] b_req_addr = 0;
   logic [1:0]  b_req_size = 0;
   logic        b_req_ready, b_mem_req_valid, b_rsp_valid, b_rsp_err, b_auto_v = 0;
   logic [31:0] b_mem_addr;
   logic [63:0] b_rsp_data, b_auto_d = 0;
   logic [63:0] mem64 [logic [31:0]];
   load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .req_size(b_req_size), .req_unsigned(b_req_unsigned), .mem_req_valid(b_mem_req_valid),
      .mem_req_ready(1'b1), .mem_addr(b_mem_addr), .mem_rsp_valid(b_auto_v),
      .mem_rdata(b_auto_d), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_data(b_rsp_data),
      .rsp_err(b_rsp_err));
   function automatic logic [31:0] rd32(input logic [31:0] a);
      return mem32.exists(a) ? mem32[a] : 32'h0;
   endfunction
   function automatic logic [63:0] rd64(input logic [31:0] a);
      return mem64.exists(a) ? mem64[a] : 64'h0;
   endfunction
   always @(posedge clk) begin
      auto_v   <= mem_req_valid && mem_req_ready;
      auto_d   <= rd32(mem_addr);
      b_auto_v <= b_mem_req_valid;
      b_auto_d <= rd64(b_mem_addr);
      if (mem_req_valid && mem_req_ready) reads <= reads + 1;
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] w;
      w = rd32({a[31:2], 2'b00});
      return 8'(w >> (8 * (3 - int'(a[1:0]))));
   endfunction
   // Reference: gather the N addressed bytes one at a time from a byte-addressed view of memory.
   function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic u,
                                 output logic [31:0] d, output logic e, output int r);
      int n, ofs;
      logic [63:0] v;
      n   = sz == 2 ? 1 : sz == 1 ? 2 : sz == 0 ? 4 : 8;
      ofs = int'(a[1:0]);
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      e = sz == 3;
`else
      e = (sz == 3) || (ofs % n != 0);
`endif
      d = 0;
      r = 0;
      if (!e) begin
         r = (ofs + n > 4) ? 2 : 1;
         v = 0;
         for (int i = 0; i < n; i++) v = (v << 8) | 64'(byte_at(a + 32'(i)));
         if (!u && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
         d = v[31:0];
      end
   endfunction
   task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] ed, input logic ee, input int er, input string nm);
      int r0, n;
      @(negedge clk);
      req_valid = 1; req_addr = a; req_size = sz; req_unsigned = u; r0 = reads;
      chk({nm, "_rdy"}, 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 0;
      chk({nm, "_lat"}, 64'(ee ? rsp_valid : mem_req_valid), 64'd1);
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_done"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_data"}, 64'(rsp_data), 64'(ed));
      chk({nm, "_err"}, 64'(rsp_err), 64'(ee));
      chk({nm, "_reads"}, 64'(reads - r0), 64'(er));
      @(negedge clk);
      chk({nm, "_clr"}, 64'(rsp_valid), 64'd0);
   endtask
   task automatic load64(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [63:0] ed, input logic ee, input string nm);
      int n;
      @(negedge clk);
      b_req_valid = 1; b_req_addr = a; b_req_size = sz; b_req_unsigned = u;
      @(negedge clk);
      b_req_valid = 0;
      n = 0;
      while (!b_rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk({nm, "_done"}, 64'(b_rsp_valid), 64'd1);
      chk({nm, "_data"}, b_rsp_data, ed);
      chk({nm, "_err"}, 64'(b_rsp_err), 64'(ee));
   endtask
   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] d;
      logic        e;
      int          r;
   } vec_t;
   vec_t tv [11];
   initial begin
      logic [31:0] md;
      logic        me, seen;
      int          mr, n;
      tv[0] = '{32'h100, 2'd2, 1'b0, 32'hFFFFFF80, 1'b0, 1};
      tv[1] = '{32'h100, 2'd2, 1'b1, 32'h00000080, 1'b0, 1};
      tv[2] = '{32'h103, 2'd2, 1'b0, 32'hFFFFFFC3, 1'b0, 1};
      tv[3] = '{32'h102, 2'd1, 1'b0, 32'hFFFFB2C3, 1'b0, 1};
      tv[4] = '{32'h102, 2'd1, 1'b1, 32'h0000B2C3, 1'b0, 1};
      tv[5] = '{32'h100, 2'd0, 1'b0, 32'h80A1B2C3, 1'b0, 1};
      tv[6] = '{32'h101, 2'd2, 1'b1, 32'h000000A1, 1'b0, 1};
      tv[7] = '{32'h100, 2'd3, 1'b0, 32'h0, 1'b1, 0};
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      tv[8]  = '{32'h103, 2'd1, 1'b0, 32'hFFFFC311, 1'b0, 2};
      tv[9]  = '{32'h101, 2'd1, 1'b1, 32'h0000A1B2, 1'b0, 1};
      tv[10] = '{32'h102, 2'd0, 1'b0, 32'hB2C31122, 1'b0, 2};
`else
      tv[8]  = '{32'h103, 2'd1, 1'b0, 32'h0, 1'b1, 0};
      tv[9]  = '{32'h101, 2'd1, 1'b1, 32'h0, 1'b1, 0};
      tv[10] = '{32'h102, 2'd0, 1'b0, 32'h0, 1'b1, 0};
`endif
      mem32[32'h100] = 32'h80A1B2C3;
      mem32[32'h104] = 32'h11223344;
      mem64[32'h8]   = 64'h8000000000000001;
      #1 rst_n = 0;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 11; i++)
         load(tv[i].a, tv[i].sz, tv[i].u, tv[i].d, tv[i].e, tv[i].r, $sformatf("vec%0d", i));
      // Memory and consumer backpressure on a half load from the second word.
      mem_req_ready = 0;
      @(negedge clk);
      req_valid = 1; req_addr = 32'h106; req_size = 2'd1; req_unsigned = 0;
      @(negedge clk);
      req_valid = 0;
      repeat (4) begin
         chk("bp_mem_valid", 64'(mem_req_valid), 64'd1);
         chk("bp_mem_addr", 64'(mem_addr), 64'h104);
         @(negedge clk);
      end
      mem_req_ready = 1;
      rsp_ready = 0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      repeat (3) begin
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_data", 64'(rsp_data), 64'h00003344);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1;
      @(negedge clk);
      chk("bp_release", 64'(rsp_valid), 64'd0);
      // Reset while waiting on memory, followed by a stale response.
      mem_auto = 0;
      @(negedge clk);
      req_valid = 1; req_addr = 32'h100; req_size = 2'd0;
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      chk("rst_mid_wait", 64'(mem_req_valid), 64'd0);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      man_v = 1; man_d = 32'hDEADBEEF;
      @(negedge clk);
      man_v = 0;
      seen = 0;
      repeat (5) begin seen |= rsp_valid; @(negedge clk); end
      chk("rst_mid_no_rsp", 64'(seen), 64'd0);
      chk("rst_mid_idle", 64'(req_ready), 64'd1);
      mem_auto = 1;
      load(32'h100, 2'd0, 1'b0, 32'h80A1B2C3, 1'b0, 1, "post_rst");
      load64(32'h8, 2'd3, 1'b0, 64'h8000000000000001, 1'b0, "d64_dword");
      load64(32'h8, 2'd0, 1'b0, 64'h8000000000000001, 1'b0, "d64_word");
      load64(32'hF, 2'd2, 1'b1, 64'h01, 1'b0, "d64_byte");
      load64(32'h8, 2'd1, 1'b0, 64'hFFFFFFFFFFFF8000, 1'b0, "d64_half");
`ifdef LOAD_ALIGN_MISALIGN_SPLIT_EN
      load64(32'hC, 2'd3, 1'b0, 64'h0000000100000000, 1'b0, "d64_split");
`else
      load64(32'hC, 2'd3, 1'b0, 64'h0, 1'b1, "d64_misal");
`endif
      for (int i = 0; i < 48; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         logic        u;
         if (i % 8 == 0)
            for (int k = 0; k < 4; k++) mem32[32'h100 + 32'(4 * k)] = $urandom;
         a  = 32'h100 + 32'($urandom_range(0, 11));
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         model(a, sz, u, md, me, mr);
         load(a, sz, u, md, me, mr, $sformatf("rnd%0d", i));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
